temp_monitor: RTL and testbench
===============================

Name: temp_monitor

Overview:
- Consumes the 8-bit Celsius sample stream from the on-die temperature-sense front end (degrees_c with fresh_sample/failed_sample pulses).
- Produces a boxcar-averaged temperature, hysteretic warning and sticky critical alarms, and a sensor-fault flag.
- Sits between the sense block and the system health/fan-control logic.

Parameters:
- AVG_LOG2, 3, log2 of averaging window depth (N = 2^AVG_LOG2 samples, legal 1..6).
- WARN_HI, 8'd85, warn set threshold in degrees C (averaged value >= WARN_HI).
- WARN_LO, 8'd80, warn clear threshold (averaged value < WARN_LO); WARN_LO <= WARN_HI required.
- CRIT_TH, 8'd100, critical threshold (averaged value >= CRIT_TH).
- FAIL_LIMIT, 4, consecutive failed samples needed to declare sensor fault (1..255).

Ports:
- clk  in  1  system clock, same domain as the sense block.
- srst  in  1  reset; synchronous, active-high.
- degrees_c  in  8  unsigned sample; valid only when fresh_sample is high.
- fresh_sample  in  1  single-cycle pulse: new valid sample.
- failed_sample  in  1  single-cycle pulse: conversion failed.
- crit_clr  in  1  single-cycle request to clear the sticky crit flag.
- avg_c  out  8  averaged temperature, unsigned degrees C.
- avg_valid  out  1  single-cycle pulse when avg_c updates.
- warn  out  1  hysteretic warning level.
- crit  out  1  sticky critical alarm.
- sensor_fault  out  1  consecutive-failure fault level.
- fail_count  out  8  total failed samples since reset, saturating at 255.

Behaviour:
- Reset (srst high at a clk edge):
  - All outputs go to 0.
  - Ring write pointer, fill count, running sum and consecutive-fail counter go to 0.
  - Ring contents need not be cleared; the fill count masks them.
- Sample acceptance:
  - A fresh_sample at cycle t writes degrees_c into ring[wr_ptr] at t+1.
  - At the same edge: sum <= sum + degrees_c - oldest, where oldest = ring[wr_ptr] when fill == N, else 0.
  - wr_ptr wraps modulo N.
  - fill increments and saturates at N.
- Sum width is 8+AVG_LOG2 bits and cannot overflow.
- States:
  - FILLING (fill < N): no avg_valid is emitted.
  - RUNNING (fill == N): stays RUNNING until srst.
  - The FILLING -> RUNNING transition occurs on the Nth accepted sample.
- Output latency: in RUNNING, avg_c <= sum >> AVG_LOG2 (truncating) and avg_valid pulses at t+2. That is 2 cycles from fresh_sample, including the sample that completes the fill.
- Alarms are evaluated on the same edge avg_c updates, using the new average:
  - warn: set if avg >= WARN_HI; clear if avg < WARN_LO; otherwise hold.
  - crit: set if avg >= CRIT_TH.
  - crit_clr clears crit. If crit_clr coincides with a set condition, set wins.
  - warn and crit change only on avg_valid cycles.
- Failures:
  - failed_sample increments the consecutive counter (saturating at FAIL_LIMIT) and fail_count (saturating at 255).
  - sensor_fault rises on the cycle after the FAIL_LIMIT-th consecutive failure.
  - A fresh_sample zeroes the consecutive counter and clears sensor_fault on the next cycle.
  - Failures do not disturb the ring, the sum or avg_valid.
- Simultaneous fresh_sample and failed_sample: fresh wins and the failure is ignored entirely, including in fail_count.
- Back-to-back fresh_sample on consecutive cycles must be handled at full rate.

Optional Feature:
- Macro: TEMP_MONITOR_PEAK_EN.
- With the macro defined:
  - Adds output peak_c[7:0], the maximum avg_c since reset or since the last crit_clr.
  - peak_c updates on avg_valid cycles.
  - On crit_clr, peak_c reloads with the current avg_c.
  - peak_c resets to 0.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package temp_monitor_pkg holds:
  - default threshold constants (WARN_HI/WARN_LO/CRIT_TH);
  - the fill-state enum (FILLING, RUNNING);
  - a function for sum width (8+AVG_LOG2).
- Sub-module temp_avg_ring contains the ring buffer, pointer, fill count, running sum and state. It outputs sum and running.
- The top level keeps alarms, failure counters and the optional peak logic.

Test Plan (defaults, N=8):
- Eight fresh samples of 40: avg_valid absent for samples 1-7; pulse 2 cycles after the 8th with avg_c=40; warn=crit=0.
- Then seven samples of 90: avg_c=83 after the 7th, warn=0. Eighth sample of 90: avg_c=90, warn=1. Then eight samples of 82: warn stays 1. Then eight of 79: warn=0 once avg_c=79.
- Eight samples of 105: crit=1 at avg_c>=100. Then eight of 50: crit stays 1. Pulse crit_clr: crit=0. Pulse crit_clr in the same cycle as a 105-average update: crit stays 1.
- Three failed_sample pulses: sensor_fault=0, fail_count=3. Fourth pulse: sensor_fault=1 next cycle. One fresh_sample: sensor_fault=0, fail_count stays 4. 300 failures: fail_count=255.
- fresh_sample and failed_sample together: sample accepted, fail_count unchanged. 8 back-to-back fresh cycles of 60: avg_c=60.
- srst asserted after 5 of 8 fill samples: all outputs 0. Next 7 samples give no avg_valid; the 8th does.

Source files
------------

// File: rtl/temp_monitor_pkg.sv
// Shared constants, fill-state type and width helper for the temperature monitor.
package temp_monitor_pkg;

    localparam int         AVG_LOG2_DEF   = 3;
    localparam logic [7:0] WARN_HI_DEF    = 8'd85;
    localparam logic [7:0] WARN_LO_DEF    = 8'd80;
    localparam logic [7:0] CRIT_TH_DEF    = 8'd100;
    localparam int         FAIL_LIMIT_DEF = 4;

    typedef enum logic {
        FILLING = 1'b0,
        RUNNING = 1'b1
    } fill_state_e;

    // Running sum of 2^avg_log2 eight-bit samples never exceeds this width.
    function automatic int sum_width(input int avg_log2);
        return 8 + avg_log2;
    endfunction

endpackage

// File: rtl/temp_monitor_if.sv
// Sample stream from the temperature-sense front end: one value plus fresh/failed pulses.
interface temp_monitor_if;

    logic [7:0] degrees_c;
    logic       fresh_sample;
    logic       failed_sample;

    modport master (
        output degrees_c,
        output fresh_sample,
        output failed_sample
    );

    modport slave (
        input degrees_c,
        input fresh_sample,
        input failed_sample
    );

endinterface

// File: rtl/temp_avg_ring.sv
// Boxcar ring: stores the last 2^AVG_LOG2 samples and keeps their running sum.
module temp_avg_ring
    import temp_monitor_pkg::*;
#(
    parameter  int AVG_LOG2 = AVG_LOG2_DEF,
    localparam int SUM_W    = sum_width(AVG_LOG2)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             fresh_sample,
    input  logic [7:0]       degrees_c,
    output logic [SUM_W-1:0] sum,
    output logic             running,
    output logic             sum_upd
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [7:0]          ring_mem [N];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [FILL_W-1:0]   fill;
    fill_state_e         state_q, state_d;
    logic [7:0]          oldest;

    // NOTE: every variable driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        oldest  = 8'd0;
        if (state_q == RUNNING) begin
            oldest = ring_mem[wr_ptr];
        end
        if (fresh_sample && state_q == FILLING && fill == FILL_W'(N - 1)) begin
            state_d = RUNNING;
        end
    end

    // NOTE: the ring has no reset; the fill state masks stale entries until they are overwritten.
    always_ff @(posedge clk) begin
        if (fresh_sample) begin
            ring_mem[wr_ptr] <= degrees_c;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= FILLING;
            wr_ptr  <= '0;
            fill    <= '0;
            sum     <= '0;
            sum_upd <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_upd <= fresh_sample;
            if (fresh_sample) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum + SUM_W'(degrees_c) - SUM_W'(oldest);
                if (state_q == FILLING) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    assign running = (state_q == RUNNING);

endmodule

// File: rtl/temp_monitor.sv
// Averaged temperature with warn/crit alarms and sensor-fault tracking.
// Optional peak_c output is enabled by defining TEMP_MONITOR_PEAK_EN.
module temp_monitor
    import temp_monitor_pkg::*;
#(
    parameter int         AVG_LOG2   = AVG_LOG2_DEF,
    parameter logic [7:0] WARN_HI    = WARN_HI_DEF,
    parameter logic [7:0] WARN_LO    = WARN_LO_DEF,
    parameter logic [7:0] CRIT_TH    = CRIT_TH_DEF,
    parameter int         FAIL_LIMIT = FAIL_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       srst,
    temp_monitor_if.slave smp,
    input  logic       crit_clr,
    output logic [7:0] avg_c,
    output logic       avg_valid,
    output logic       warn,
    output logic       crit,
    output logic       sensor_fault,
`ifdef TEMP_MONITOR_PEAK_EN
    output logic [7:0] peak_c,
`endif
    output logic [7:0] fail_count
);

    localparam int         SUM_W    = sum_width(AVG_LOG2);
    localparam logic [7:0] FAIL_LIM = 8'(FAIL_LIMIT);

    logic [SUM_W-1:0] sum;
    logic             running;
    logic             sum_upd;
    logic             avg_upd;
    logic [7:0]       avg_new;
    logic             fail_evt;
    logic [7:0]       consec_q, consec_d;
    logic             warn_d, crit_d;

    temp_avg_ring #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_ring (
        .clk          (clk),
        .srst         (srst),
        .fresh_sample (smp.fresh_sample),
        .degrees_c    (smp.degrees_c),
        .sum          (sum),
        .running      (running),
        .sum_upd      (sum_upd)
    );

    assign avg_upd  = sum_upd && running;
    assign avg_new  = 8'(sum >> AVG_LOG2);
    // A coincident fresh sample wins; the failure is dropped entirely.
    assign fail_evt = smp.failed_sample && !smp.fresh_sample;

    always_comb begin
        consec_d = consec_q;
        warn_d   = warn;
        crit_d   = crit;
        if (smp.fresh_sample) begin
            consec_d = 8'd0;
        end else if (fail_evt && consec_q != FAIL_LIM) begin
            consec_d = consec_q + 8'd1;
        end
        if (avg_upd) begin
            if (avg_new >= WARN_HI) begin
                warn_d = 1'b1;
            end else if (avg_new < WARN_LO) begin
                warn_d = 1'b0;
            end
        end
        // A set condition on an update edge overrides a simultaneous clear request.
        if (avg_upd && avg_new >= CRIT_TH) begin
            crit_d = 1'b1;
        end else if (crit_clr) begin
            crit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            avg_c        <= 8'd0;
            avg_valid    <= 1'b0;
            warn         <= 1'b0;
            crit         <= 1'b0;
            sensor_fault <= 1'b0;
            fail_count   <= 8'd0;
            consec_q     <= 8'd0;
        end else begin
            avg_valid    <= avg_upd;
            warn         <= warn_d;
            crit         <= crit_d;
            consec_q     <= consec_d;
            sensor_fault <= (consec_d >= FAIL_LIM);
            if (avg_upd) begin
                avg_c <= avg_new;
            end
            if (fail_evt && fail_count != 8'hFF) begin
                fail_count <= fail_count + 8'd1;
            end
        end
    end

`ifdef TEMP_MONITOR_PEAK_EN
    logic [7:0] peak_d;

    always_comb begin
        peak_d = peak_c;
        if (crit_clr) begin
            peak_d = avg_upd ? avg_new : avg_c;
        end else if (avg_upd && avg_new > peak_c) begin
            peak_d = avg_new;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            peak_c <= 8'd0;
        end else begin
            peak_c <= peak_d;
        end
    end
`endif

endmodule

// File: tb/tb_temp_monitor.sv
// Directed self-checking bench for temp_monitor at default parameters (N = 8).
module tb_temp_monitor;

    logic       clk;
    logic       srst;
    logic       crit_clr;
    logic [7:0] avg_c;
    logic       avg_valid;
    logic       warn;
    logic       crit;
    logic       sensor_fault;
    logic [7:0] fail_count;
`ifdef TEMP_MONITOR_PEAK_EN
    logic [7:0] peak_c;
`endif

    int n_vec;
    int n_bad;
    int pulses;

    temp_monitor_if smp ();

    temp_monitor dut (
        .clk          (clk),
        .srst         (srst),
        .smp          (smp),
        .crit_clr     (crit_clr),
        .avg_c        (avg_c),
        .avg_valid    (avg_valid),
        .warn         (warn),
        .crit         (crit),
        .sensor_fault (sensor_fault),
`ifdef TEMP_MONITOR_PEAK_EN
        .peak_c       (peak_c),
`endif
        .fail_count   (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
    endtask

    // One sample, then observe two cycles later where its avg_valid pulse belongs.
    task automatic send(input logic [7:0] d, input logic exp_valid, input logic clr_on_update);
        @(negedge clk);
        smp.degrees_c    = d;
        smp.fresh_sample = 1'b1;
        @(negedge clk);
        smp.fresh_sample = 1'b0;
        crit_clr         = clr_on_update;
        @(negedge clk);
        crit_clr = 1'b0;
        check("avg_valid", avg_valid, exp_valid);
    endtask

    task automatic fail_pulse();
        @(negedge clk);
        smp.failed_sample = 1'b1;
        @(negedge clk);
        smp.failed_sample = 1'b0;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec             = 0;
        n_bad             = 0;
        srst              = 1'b1;
        crit_clr          = 1'b0;
        smp.degrees_c     = 8'd0;
        smp.fresh_sample  = 1'b0;
        smp.failed_sample = 1'b0;
        do_reset();
        check("rst avg_c", avg_c, 8'd0);
        check("rst avg_valid", avg_valid, 1'b0);
        check("rst warn", warn, 1'b0);
        check("rst crit", crit, 1'b0);
        check("rst sensor_fault", sensor_fault, 1'b0);
        check("rst fail_count", fail_count, 8'd0);

        // Fill with 40: only the eighth sample produces an average.
        for (int i = 0; i < 7; i++) send(8'd40, 1'b0, 1'b0);
        send(8'd40, 1'b1, 1'b0);
        check("fill40 avg_c", avg_c, 8'd40);
        check("fill40 warn", warn, 1'b0);
        check("fill40 crit", crit, 1'b0);

        // 90s: 83 after seven (below WARN_HI), 90 after eight.
        for (int i = 0; i < 7; i++) send(8'd90, 1'b1, 1'b0);
        check("90x7 avg_c", avg_c, 8'd83);
        check("90x7 warn", warn, 1'b0);
        send(8'd90, 1'b1, 1'b0);
        check("90x8 avg_c", avg_c, 8'd90);
        check("90x8 warn", warn, 1'b1);

        // 82s: average walks 89..82, inside the hysteresis band.
        for (int i = 0; i < 8; i++) send(8'd82, 1'b1, 1'b0);
        check("82 avg_c", avg_c, 8'd82);
        check("82 warn hold", warn, 1'b1);

        // 79s: averages 81,81,80,80,80,79,79,79; clears only at 79.
        for (int i = 0; i < 5; i++) send(8'd79, 1'b1, 1'b0);
        check("79x5 avg_c", avg_c, 8'd80);
        check("79x5 warn at 80", warn, 1'b1);
        send(8'd79, 1'b1, 1'b0);
        check("79x6 avg_c", avg_c, 8'd79);
        check("79x6 warn clr", warn, 1'b0);
        send(8'd79, 1'b1, 1'b0);
        send(8'd79, 1'b1, 1'b0);

        // 105s: averages 82,85,88,92,95,98,101,105.
        send(8'd105, 1'b1, 1'b0);
        check("105x1 warn band", warn, 1'b0);
        send(8'd105, 1'b1, 1'b0);
        check("105x2 avg_c", avg_c, 8'd85);
        check("105x2 warn set", warn, 1'b1);
        for (int i = 0; i < 4; i++) send(8'd105, 1'b1, 1'b0);
        check("105x6 avg_c", avg_c, 8'd98);
        check("105x6 crit", crit, 1'b0);
        send(8'd105, 1'b1, 1'b0);
        check("105x7 avg_c", avg_c, 8'd101);
        check("105x7 crit", crit, 1'b1);
        send(8'd105, 1'b1, 1'b0);

        // 50s: crit is sticky, warn drops at 77.
        for (int i = 0; i < 8; i++) send(8'd50, 1'b1, 1'b0);
        check("50 avg_c", avg_c, 8'd50);
        check("50 crit sticky", crit, 1'b1);
        check("50 warn", warn, 1'b0);

        @(negedge clk);
        crit_clr = 1'b1;
        @(negedge clk);
        crit_clr = 1'b0;
        check("crit_clr", crit, 1'b0);

        // Back to 105: 98 after seven, then clear coincides with the 105 update.
        for (int i = 0; i < 7; i++) send(8'd105, 1'b1, 1'b0);
        check("re105x7 avg_c", avg_c, 8'd98);
        check("re105x7 crit", crit, 1'b0);
        send(8'd105, 1'b1, 1'b1);
        check("clr vs set avg_c", avg_c, 8'd105);
        check("clr vs set crit", crit, 1'b1);

        // Failures.
        for (int i = 0; i < 3; i++) fail_pulse();
        check("fail3 sensor_fault", sensor_fault, 1'b0);
        check("fail3 fail_count", fail_count, 8'd3);
        fail_pulse();
        check("fail4 sensor_fault", sensor_fault, 1'b1);
        check("fail4 fail_count", fail_count, 8'd4);
        send(8'd105, 1'b1, 1'b0);
        check("fresh clears fault", sensor_fault, 1'b0);
        check("fresh fail_count", fail_count, 8'd4);

        // Coincident fresh and failed: sample taken, failure ignored, consecutive count zeroed.
        for (int i = 0; i < 3; i++) fail_pulse();
        check("fail7 fail_count", fail_count, 8'd7);
        @(negedge clk);
        smp.degrees_c     = 8'd105;
        smp.fresh_sample  = 1'b1;
        smp.failed_sample = 1'b1;
        @(negedge clk);
        smp.fresh_sample  = 1'b0;
        smp.failed_sample = 1'b0;
        @(negedge clk);
        check("both avg_valid", avg_valid, 1'b1);
        check("both avg_c", avg_c, 8'd105);
        check("both fail_count", fail_count, 8'd7);
        fail_pulse();
        check("after both fault", sensor_fault, 1'b0);
        check("after both fail_count", fail_count, 8'd8);

        // 300 back-to-back failures saturate fail_count.
        @(negedge clk);
        smp.failed_sample = 1'b1;
        repeat (300) @(negedge clk);
        smp.failed_sample = 1'b0;
        check("sat fail_count", fail_count, 8'd255);
        check("sat sensor_fault", sensor_fault, 1'b1);

        // Eight full-rate samples of 60 give eight pulses.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (avg_valid) pulses++;
            smp.degrees_c    = 8'd60;
            smp.fresh_sample = (i < 8);
        end
        check("b2b pulses", 8'(pulses), 8'd8);
        check("b2b avg_c", avg_c, 8'd60);
        check("b2b sensor_fault", sensor_fault, 1'b0);
        check("b2b warn", warn, 1'b0);

        // Reset in mid-fill.
        do_reset();
        check("srst avg_c", avg_c, 8'd0);
        check("srst crit", crit, 1'b0);
        check("srst fail_count", fail_count, 8'd0);
        for (int i = 0; i < 5; i++) send(8'd70, 1'b0, 1'b0);
        do_reset();
        check("srst2 avg_c", avg_c, 8'd0);
        check("srst2 avg_valid", avg_valid, 1'b0);
        for (int i = 0; i < 7; i++) send(8'd70, 1'b0, 1'b0);
        send(8'd70, 1'b1, 1'b0);
        check("refill avg_c", avg_c, 8'd70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
